// File: rtl/active_list_recovery_walker_pkg.sv
// Shared types and constants for the active list recovery walker.
package active_list_recovery_walker_pkg;

    // Default instantiation parameters (match the active list build).
    localparam int ENTRY_NUM_DEF = 64;
    localparam int WIDTH_DEF     = 4;
    localparam int DATA_BITS_DEF = 32;

    // Walker FSM encoding.
    typedef logic [1:0] walker_state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter and entry types at default parameters.
    typedef logic [$clog2(ENTRY_NUM_DEF+1)-1:0] walk_count_t;
    typedef logic [$clog2(WIDTH_DEF+1)-1:0]     pop_count_t;
    typedef walk_count_t                        active_list_count_t;
    typedef logic [DATA_BITS_DEF-1:0]           active_list_entry_t;

endpackage

// File: rtl/active_list_recovery_walker_if.sv
// Recovery-walk bus between the recovery manager / active list and the walker.
interface active_list_recovery_walker_if
    import active_list_recovery_walker_pkg::*;
#(
    parameter int ENTRY_NUM = ENTRY_NUM_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
);
    localparam int CW = $clog2(ENTRY_NUM + 1);
    localparam int PW = $clog2(WIDTH + 1);

    logic                              start;
    logic [CW-1:0]                     entryNum;
    logic                              hold;
    logic [WIDTH-1:0][DATA_BITS-1:0]   readData;
    logic [PW-1:0]                     popTailNum;
    logic [WIDTH-1:0]                  restoreValid;
    logic [WIDTH-1:0][DATA_BITS-1:0]   restoreData;
    logic                              busy;
    logic                              done;

    modport master (
        output start, entryNum, hold, readData,
        input  popTailNum, restoreValid, restoreData, busy, done
    );

    modport slave (
        input  start, entryNum, hold, readData,
        output popTailNum, restoreValid, restoreData, busy, done
    );

endinterface

// File: rtl/active_list_recovery_walker.sv
// Pops squashed entries off the active list tail, up to WIDTH per cycle,
// and forwards them youngest-first to rename-map / free-list restore.
module active_list_recovery_walker
    import active_list_recovery_walker_pkg::*;
#(
    parameter int ENTRY_NUM = ENTRY_NUM_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    active_list_recovery_walker_if.slave  bus
);
    localparam int CW = $clog2(ENTRY_NUM + 1);
    localparam int PW = $clog2(WIDTH + 1);

    walker_state_t  state;
    logic [CW-1:0]  remaining;
    logic [CW-1:0]  remaining_next;
    logic [CW-1:0]  entry_sat;
    logic [PW-1:0]  pop;
    logic           walking;

    // Out-of-range counts clamp to the list depth rather than over-popping.
    assign entry_sat = (bus.entryNum > CW'(ENTRY_NUM)) ? CW'(ENTRY_NUM) : bus.entryNum;

    // A restart suppresses the pop of the cycle it arrives in.
    assign walking        = (state == WALK) && !bus.hold && !bus.start;
    assign pop            = !walking ? '0 :
                            (remaining > CW'(WIDTH)) ? PW'(WIDTH) : PW'(remaining);
    assign remaining_next = remaining - CW'(pop);

    assign bus.popTailNum  = pop;
    assign bus.restoreData = bus.readData;
    assign bus.busy        = (state == WALK);
    assign bus.done        = (state == DONE);

    // Lane i is valid when it lies within this cycle's pop count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign bus.restoreValid[i] = (PW'(i) < pop);
    end

    // Walk FSM and remaining-entry counter; start always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
        end else if (bus.start) begin
            remaining <= entry_sat;
            state     <= (entry_sat == '0) ? DONE : WALK;
        end else begin
            case (state)
                WALK: begin
                    remaining <= remaining_next;
                    if (remaining_next == '0) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RSD_SYNTHESIS
    logic [CW-1:0] popped_sum;
    logic [CW-1:0] walk_target;

    // Track entries popped since the latest start for the sum check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            popped_sum  <= '0;
            walk_target <= '0;
        end else if (bus.start) begin
            popped_sum  <= '0;
            walk_target <= entry_sat;
        end else begin
            popped_sum  <= popped_sum + CW'(pop);
        end
    end

    // Range check on entryNum and exact-count check at completion.
    always @(posedge clk) begin
        if (rst) begin
            if (bus.start)
                assert (bus.entryNum <= CW'(ENTRY_NUM))
                    else $error("entryNum %0d exceeds ENTRY_NUM", bus.entryNum);
            if (state == DONE)
                assert (popped_sum == walk_target)
                    else $error("popped %0d entries, expected %0d", popped_sum, walk_target);
        end
    end
`endif

endmodule

// File: tb/tb_active_list_recovery_walker.sv
// Scoreboard bench for the active list recovery walker (default parameters).
module tb_active_list_recovery_walker;
    import active_list_recovery_walker_pkg::*;

    typedef struct packed {
        logic [2:0]   pop;
        logic [3:0]   vld;
        logic         busy;
        logic         done;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pop_sum = 0;
    int   cyc     = 0;
    exp_t q[$];

    active_list_recovery_walker_if bus ();

    active_list_recovery_walker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, compare at negedge.
    task automatic step(input string name, input logic st, input logic [6:0] en, input logic hd,
                        input logic [2:0] p, input logic [3:0] v, input logic b, input logic d);
        exp_t e;
        exp_t o;
        bus.start    = st;
        bus.entryNum = en;
        bus.hold     = hd;
        bus.readData = {$urandom, $urandom, $urandom, $urandom};
        e.pop = p; e.vld = v; e.busy = b; e.done = d; e.data = bus.readData;
        q.push_back(e);
        if (st) pop_sum = 0;
        @(negedge clk);
        o = q.pop_front();
        chk({name, ".pop"},  128'(bus.popTailNum),   128'(o.pop));
        chk({name, ".vld"},  128'(bus.restoreValid), 128'(o.vld));
        chk({name, ".busy"}, 128'(bus.busy),         128'(o.busy));
        chk({name, ".done"}, 128'(bus.done),         128'(o.done));
        chk({name, ".data"}, bus.restoreData,        o.data);
        pop_sum += int'(bus.popTailNum);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.entryNum = '0;
        bus.hold     = 1'b0;
        bus.readData = '0;
        #1;
        chk("rst.pop",  128'(bus.popTailNum),   128'(0));
        chk("rst.vld",  128'(bus.restoreValid), 128'(0));
        chk("rst.busy", 128'(bus.busy),         128'(0));
        chk("rst.done", 128'(bus.done),         128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // entryNum=10: pops 4,4,2 then done
        step("t10", 1, 10, 0, 0, 4'b0000, 0, 0);
        step("t10", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("t10", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("t10", 0, 0, 0, 2, 4'b0011, 1, 0);
        step("t10", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("t10", 0, 0, 0, 0, 4'b0000, 0, 0);
        chk("t10.sum", 128'(pop_sum), 128'(10));

        // entryNum=0: done next cycle, never busy
        step("t0", 1, 0, 0, 0, 4'b0000, 0, 0);
        step("t0", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("t0", 0, 0, 0, 0, 4'b0000, 0, 0);

        // entryNum=9 with two hold cycles: 4,0,0,4,1
        step("t9h", 1, 9, 0, 0, 4'b0000, 0, 0);
        step("t9h", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("t9h", 0, 0, 1, 0, 4'b0000, 1, 0);
        step("t9h", 0, 0, 1, 0, 4'b0000, 1, 0);
        step("t9h", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("t9h", 0, 0, 0, 1, 4'b0001, 1, 0);
        step("t9h", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("t9h", 0, 0, 0, 0, 4'b0000, 0, 0);
        chk("t9h.sum", 128'(pop_sum), 128'(9));

        // entryNum=12 restarted with 3: 4,0,3 and one done
        step("trs", 1, 12, 0, 0, 4'b0000, 0, 0);
        step("trs", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("trs", 1, 3, 0, 0, 4'b0000, 1, 0);
        step("trs", 0, 0, 0, 3, 4'b0111, 1, 0);
        step("trs", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("trs", 0, 0, 0, 0, 4'b0000, 0, 0);
        chk("trs.sum", 128'(pop_sum), 128'(3));

        // Restart from DONE with entryNum=4: no second done in between
        step("tdr", 1, 1, 0, 0, 4'b0000, 0, 0);
        step("tdr", 0, 0, 0, 1, 4'b0001, 1, 0);
        step("tdr", 1, 4, 0, 0, 4'b0000, 0, 1);
        step("tdr", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("tdr", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("tdr", 0, 0, 0, 0, 4'b0000, 0, 0);

        // Full list: 16 pops of 4
        step("t64", 1, 64, 0, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 16; i++) step("t64", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("t64", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("t64", 0, 0, 0, 0, 4'b0000, 0, 0);
        chk("t64.sum", 128'(pop_sum), 128'(64));

        // Reset mid-walk: outputs clear immediately, no done afterwards
        step("trst", 1, 10, 0, 0, 4'b0000, 0, 0);
        step("trst", 0, 0, 0, 4, 4'b1111, 1, 0);
        rst = 1'b0;
        #1;
        chk("trst.pop",  128'(bus.popTailNum),   128'(0));
        chk("trst.vld",  128'(bus.restoreValid), 128'(0));
        chk("trst.busy", 128'(bus.busy),         128'(0));
        chk("trst.done", 128'(bus.done),         128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("trst", 0, 0, 0, 0, 4'b0000, 0, 0);
        step("trst", 0, 0, 0, 0, 4'b0000, 0, 0);
        step("tpost", 1, 5, 0, 0, 4'b0000, 0, 0);
        step("tpost", 0, 0, 0, 4, 4'b1111, 1, 0);
        step("tpost", 0, 0, 0, 1, 4'b0001, 1, 0);
        step("tpost", 0, 0, 0, 0, 4'b0000, 0, 1);
        step("tpost", 0, 0, 0, 0, 4'b0000, 0, 0);
        chk("tpost.sum", 128'(pop_sum), 128'(5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
